pcie_link_seq: RTL and testbench
================================

Name: pcie_link_seq

Overview:
- Bring-up sequencer for the host/endpoint PcieVhost pair in the top-level bench.
- Drives the models' active-low reset and holds it for a programmed number of cycles.
- Then waits for every active lane in both directions to leave electrical idle and stay out for a stability window, and flags link-up.
- Services hot-reset requests and runs a global watchdog that raises a sticky fatal.

Parameters:
- RESET_CYCLES, 11: cycles notResetOut is held low after Reset release or a hot reset (1..255).
- STABLE_CYCLES, 16: consecutive cycles with all active lanes out of idle before LinkUp (1..65535).
- TIMEOUT_COUNT, 32'd1000000: watchdog limit in Clk cycles since Reset release; 0 disables the watchdog.

Ports:
- Clk  in  1  bench clock; all logic on posedge.
- Reset  in  1  asynchronous, active-high reset.
- LinkWidth  in  5  active lane count, 1..16; 0 or >16 is treated as 16.
- ElecIdleDown  in  16  per-lane electrical idle from the host transmitter.
- ElecIdleUp  in  16  per-lane electrical idle from the endpoint transmitter.
- HotResetReq  in  1  single-cycle request to re-reset the models.
- notResetOut  out  1  active-low reset to both PcieVhost instances.
- LinkUp  out  1  link trained and stable.
- Fatal  out  1  sticky watchdog expiry.
- CycleCount  out  32  free-running cycle count since Reset release.
- State  out  3  current FSM state encoding.
- RetrainCount  out  8  count of link drops detected in UP.

Behaviour:
- Reset asserted: State=HOLD, notResetOut=0, LinkUp=0, Fatal=0, CycleCount=0, RetrainCount=0, hold and stable counters = 0.
- Lane mask: LaneMask = (1<<LinkWidth)-1 (all ones when LinkWidth is invalid). Active = ~(ElecIdleDown|ElecIdleUp) & LaneMask; AllActive = (Active == LaneMask). Inputs are sampled, not synchronised.
- FSM encodings: HOLD=0, WAIT_ACTIVE=1, STABLE=2, UP=3, FATAL=7.
- HOLD:
  - Hold counter increments each cycle; notResetOut=0.
  - When the counter reaches RESET_CYCLES-1, next state is WAIT_ACTIVE and notResetOut goes 1 on that same edge.
  - notResetOut is therefore low for exactly RESET_CYCLES cycles.
- WAIT_ACTIVE: if AllActive, go to STABLE with stable counter = 1.
- STABLE:
  - If AllActive, the counter increments.
  - On the cycle the counter equals STABLE_CYCLES, go to UP and register LinkUp=1.
  - If any active lane returns to idle, go back to WAIT_ACTIVE and clear the counter.
- UP: LinkUp=1; a lane drop is handled per the optional feature.
- HotResetReq, in any state except FATAL: next state is HOLD, hold counter=0, LinkUp=0, notResetOut=0 on the next edge. This takes priority over every other transition except the watchdog.
- Watchdog:
  - CycleCount increments every cycle except in FATAL, where it freezes.
  - When TIMEOUT_COUNT != 0 and CycleCount == TIMEOUT_COUNT-1, the next state is FATAL and Fatal=1.
  - Expiry beats a simultaneous HotResetReq.
  - Expiry applies in any state, including UP.
- FATAL: absorbing state. Fatal stays 1, LinkUp=0, notResetOut=0. Only Reset exits it.
- Counters:
  - CycleCount wraps naturally only if the watchdog is disabled.
  - RetrainCount saturates at 255.
- Reset asserted mid-operation returns all outputs to their reset values asynchronously.

Optional Feature:
- Macro: PCIE_LINK_SEQ_RETRAIN_EN.
- Defined: in UP, any active lane entering idle sends the FSM to WAIT_ACTIVE, clears LinkUp on the next edge, and increments RetrainCount (saturating).
- Undefined: the same condition is treated as an error. Next state is FATAL and Fatal=1. RetrainCount stays 0.

Decomposition:
- Shared package pcie_link_seq_pkg:
  - State enum/localparams (HOLD, WAIT_ACTIVE, STABLE, UP, FATAL).
  - MAX_LANES=16.
  - Lane-mask function.
- Optional sub-module pcie_lane_mask: combinational LinkWidth to LaneMask/AllActive decode, reusable by the display modules.
- Counters and FSM remain in the top module.

Test Plan:
- Reset released with LinkWidth=4 and both idle buses driven 0 on lanes 0-3 → notResetOut rises 11 cycles after release; LinkUp rises 16 cycles after entering STABLE (State 1→2→3).
- Lane 2 of ElecIdleUp pulsed to 1 for 1 cycle at stable count 8 → State returns to WAIT_ACTIVE. LinkUp is delayed a full further 16 cycles. Lanes 4-15 driven to 1 have no effect.
- HotResetReq pulsed while in UP → LinkUp=0 and notResetOut=0 next edge; 11 cycles low, then re-training to UP.
- TIMEOUT_COUNT=50 with lanes held idle → Fatal=1 and State=7 after CycleCount reaches 49; a later HotResetReq is ignored; Reset clears everything.
- RETRAIN_EN defined, lane 0 drops in UP three times → RetrainCount=3 and LinkUp re-asserts each time. RETRAIN_EN undefined → first drop gives Fatal=1.
- LinkWidth=0 and LinkWidth=20 → behaves as 16 lanes; any single lane idle blocks UP.

Source files
------------

// File: rtl/pcie_link_seq_pkg.sv
// Shared types and helpers for the PCIe link bring-up sequencer and its lane decode.
package pcie_link_seq_pkg;

    localparam int MAX_LANES = 16;

    typedef enum logic [2:0] {
        ST_HOLD        = 3'd0,
        ST_WAIT_ACTIVE = 3'd1,
        ST_STABLE      = 3'd2,
        ST_UP          = 3'd3,
        ST_FATAL       = 3'd7
    } state_e;

    // Out-of-range widths (0 or above MAX_LANES) fall back to the full link.
    function automatic logic [MAX_LANES-1:0] lane_mask(input logic [4:0] width);
        logic [MAX_LANES-1:0] m;
        if (width == 5'd0 || width > 5'd16) m = '1;
        else m = MAX_LANES'((32'd1 << width) - 32'd1);
        return m;
    endfunction

endpackage

// File: rtl/pcie_lane_mask.sv
// Combinational decode of link width into the active-lane mask and the lanes
// currently out of electrical idle in both directions.
module pcie_lane_mask
    import pcie_link_seq_pkg::*;
(
    input  logic [4:0]           width_i,
    input  logic [MAX_LANES-1:0] idle_dn_i,
    input  logic [MAX_LANES-1:0] idle_up_i,
    output logic [MAX_LANES-1:0] mask_o,
    output logic [MAX_LANES-1:0] active_o
);

    assign mask_o   = lane_mask(width_i);
    assign active_o = ~(idle_dn_i | idle_up_i) & mask_o;

endmodule

// File: rtl/pcie_link_seq.sv
// Bring-up sequencer for the host/endpoint PcieVhost pair: reset hold, lane
// stability wait, link-up, hot reset and watchdog. PCIE_LINK_SEQ_RETRAIN_EN
// turns a lane drop in UP into a retrain instead of a fatal error.
module pcie_link_seq
    import pcie_link_seq_pkg::*;
#(
    parameter int unsigned RESET_CYCLES  = 11,
    parameter int unsigned STABLE_CYCLES = 16,
    parameter logic [31:0] TIMEOUT_COUNT = 32'd1000000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [4:0]  LinkWidth,
    input  logic [15:0] ElecIdleDown,
    input  logic [15:0] ElecIdleUp,
    input  logic        HotResetReq,
    output logic        notResetOut,
    output logic        LinkUp,
    output logic        Fatal,
    output logic [31:0] CycleCount,
    output logic [2:0]  State,
    output logic [7:0]  RetrainCount
);

    logic [MAX_LANES-1:0] lane_mask_w, lane_active_w;
    logic                 all_active;
    logic                 wd_expire;

    state_e      state_q;
    logic [7:0]  hold_q;
    logic [15:0] stab_q;
    logic [31:0] cyc_q;
    logic [7:0]  retr_q;
    logic        nrst_q, up_q, fatal_q;

    pcie_lane_mask u_lane_mask (
        .width_i   (LinkWidth),
        .idle_dn_i (ElecIdleDown),
        .idle_up_i (ElecIdleUp),
        .mask_o    (lane_mask_w),
        .active_o  (lane_active_w)
    );

    assign all_active = (lane_active_w == lane_mask_w);
    assign wd_expire  = (TIMEOUT_COUNT != 32'd0) && (cyc_q == TIMEOUT_COUNT - 32'd1)
                        && (state_q != ST_FATAL);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_HOLD;
            hold_q  <= '0;
            stab_q  <= '0;
            cyc_q   <= '0;
            retr_q  <= '0;
            nrst_q  <= 1'b0;
            up_q    <= 1'b0;
            fatal_q <= 1'b0;
        end else begin
            if (state_q != ST_FATAL) cyc_q <= cyc_q + 32'd1;

            // Watchdog outranks hot reset, which outranks normal sequencing.
            if (wd_expire) begin
                state_q <= ST_FATAL;
                fatal_q <= 1'b1;
                up_q    <= 1'b0;
                nrst_q  <= 1'b0;
            end else if (HotResetReq && state_q != ST_FATAL) begin
                state_q <= ST_HOLD;
                hold_q  <= '0;
                stab_q  <= '0;
                up_q    <= 1'b0;
                nrst_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_HOLD: begin
                        if (hold_q == 8'(RESET_CYCLES - 1)) begin
                            state_q <= ST_WAIT_ACTIVE;
                            hold_q  <= '0;
                            nrst_q  <= 1'b1;
                        end else begin
                            hold_q <= hold_q + 8'd1;
                        end
                    end
                    ST_WAIT_ACTIVE: begin
                        if (all_active) begin
                            state_q <= ST_STABLE;
                            stab_q  <= 16'd1;
                        end
                    end
                    ST_STABLE: begin
                        if (!all_active) begin
                            state_q <= ST_WAIT_ACTIVE;
                            stab_q  <= '0;
                        end else if (stab_q == 16'(STABLE_CYCLES)) begin
                            state_q <= ST_UP;
                            stab_q  <= '0;
                            up_q    <= 1'b1;
                        end else begin
                            stab_q <= stab_q + 16'd1;
                        end
                    end
                    ST_UP: begin
                        if (!all_active) begin
`ifdef PCIE_LINK_SEQ_RETRAIN_EN
                            state_q <= ST_WAIT_ACTIVE;
                            up_q    <= 1'b0;
                            if (retr_q != 8'hFF) retr_q <= retr_q + 8'd1;
`else
                            state_q <= ST_FATAL;
                            fatal_q <= 1'b1;
                            up_q    <= 1'b0;
                            nrst_q  <= 1'b0;
`endif
                        end
                    end
                    ST_FATAL: ;
                    default: begin
                        state_q <= ST_HOLD;
                        hold_q  <= '0;
                        stab_q  <= '0;
                        up_q    <= 1'b0;
                        nrst_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign notResetOut  = nrst_q;
    assign LinkUp       = up_q;
    assign Fatal        = fatal_q;
    assign CycleCount   = cyc_q;
    assign State        = state_q;
    assign RetrainCount = retr_q;

endmodule

// File: tb/tb_pcie_link_seq.sv
// Randomised bench for pcie_link_seq: two instances (default watchdog and a
// 50-cycle watchdog) checked every cycle against a run-length reference model.
module tb_pcie_link_seq;

    localparam int          RC  = 11;
    localparam int          SC  = 16;
    localparam logic [31:0] TMO = 32'd1000000;
    localparam logic [31:0] WD  = 32'd50;

    logic        Clk = 1'b0;
    logic        rst, rst_wd, hot;
    logic [4:0]  lw;
    logic [15:0] eid, eiu;

    logic        nrst_m, up_m, fat_m, nrst_w, up_w, fat_w;
    logic [31:0] cc_m, cc_w;
    logic [2:0]  st_m, st_w;
    logic [7:0]  rc_m, rc_w;

    int total = 0;
    int bad   = 0;

    pcie_link_seq dut (
        .Clk(Clk), .Reset(rst), .LinkWidth(lw), .ElecIdleDown(eid), .ElecIdleUp(eiu),
        .HotResetReq(hot), .notResetOut(nrst_m), .LinkUp(up_m), .Fatal(fat_m),
        .CycleCount(cc_m), .State(st_m), .RetrainCount(rc_m)
    );

    pcie_link_seq #(.TIMEOUT_COUNT(WD)) dut_wd (
        .Clk(Clk), .Reset(rst_wd), .LinkWidth(lw), .ElecIdleDown(eid), .ElecIdleUp(eiu),
        .HotResetReq(hot), .notResetOut(nrst_w), .LinkUp(up_w), .Fatal(fat_w),
        .CycleCount(cc_w), .State(st_w), .RetrainCount(rc_w)
    );

    always #5 Clk = ~Clk;

    // Reference: reset cycles remaining, length of the current all-active run.
    typedef struct {
        int          low_left;
        int          run;
        bit          up;
        bit          fatal;
        logic [31:0] cyc;
        int          retr;
    } mdl_t;

    mdl_t m, mw;

    function automatic mdl_t mreset();
        mdl_t r;
        r.low_left = RC; r.run = 0; r.up = 0; r.fatal = 0; r.cyc = 0; r.retr = 0;
        return r;
    endfunction

    function automatic bit all_act(logic [4:0] w, logic [15:0] d, logic [15:0] u);
        int n;
        n = (w == 0 || w > 16) ? 16 : int'(w);
        for (int i = 0; i < n; i++) if (d[i] || u[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic mdl_t mstep(mdl_t c, bit aa, bit h, logic [31:0] tmo);
        mdl_t n;
        n = c;
        if (c.fatal) return n;
        n.cyc = c.cyc + 1;
        if (tmo != 0 && c.cyc == tmo - 1) begin
            n.fatal = 1; n.up = 0;
            return n;
        end
        if (h) begin
            n.low_left = RC; n.run = 0; n.up = 0;
            return n;
        end
        if (c.low_left > 0) begin
            n.low_left = c.low_left - 1; n.run = 0;
            return n;
        end
        if (c.up) begin
            if (!aa) begin
`ifdef PCIE_LINK_SEQ_RETRAIN_EN
                n.up = 0; n.run = 0;
                if (n.retr < 255) n.retr = n.retr + 1;
`else
                n.fatal = 1; n.up = 0;
`endif
            end
            return n;
        end
        n.run = aa ? c.run + 1 : 0;
        if (n.run == SC + 1) n.up = 1;
        return n;
    endfunction

    function automatic logic [31:0] exp_state(mdl_t e);
        if (e.fatal) return 7;
        if (e.low_left > 0) return 0;
        if (e.up) return 3;
        return (e.run == 0) ? 1 : 2;
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_dut(string p, mdl_t e, logic [2:0] st, logic lu, logic nr, logic ft,
                             logic [31:0] cc, logic [7:0] rc);
        chk({p, ".state"}, 32'(st), exp_state(e));
        chk({p, ".linkup"}, 32'(lu), 32'(e.up));
        chk({p, ".nrst"}, 32'(nr), 32'(!e.fatal && e.low_left == 0));
        chk({p, ".fatal"}, 32'(ft), 32'(e.fatal));
        chk({p, ".cycles"}, cc, e.cyc);
        chk({p, ".retrain"}, 32'(rc), 32'(e.retr));
    endtask

    task automatic step();
        bit aa;
        @(posedge Clk);
        aa = all_act(lw, eid, eiu);
        m  = rst    ? mreset() : mstep(m, aa, hot, TMO);
        mw = rst_wd ? mreset() : mstep(mw, aa, hot, WD);
        @(negedge Clk);
        check_dut("main", m, st_m, up_m, nrst_m, fat_m, cc_m, rc_m);
        check_dut("wd", mw, st_w, up_w, nrst_w, fat_w, cc_w, rc_w);
        hot = 1'b0;
    endtask

    // Asynchronous reset of the main instance, checked before any clock edge.
    task automatic areset_main();
        rst = 1'b1;
        #1;
        check_dut("main_async_rst", mreset(), st_m, up_m, nrst_m, fat_m, cc_m, rc_m);
        step();
        rst = 1'b0;
    endtask

    task automatic wait_up(string tag);
        int n;
        n = 0;
        while (!up_m && n < 200) begin step(); n++; end
        chk(tag, 32'(up_m), 1);
    endtask

    task automatic clean_lanes();
        eid = 16'hFFF0; eiu = 16'hFFF0;
        if (lw == 0 || lw > 16) begin eid = 16'h0; eiu = 16'h0; end
        else for (int j = 0; j < 16; j++) if (j < int'(lw)) begin eid[j] = 0; eiu[j] = 0; end
    endtask

    initial begin
        int n;
        int w;
        hot = 0; lw = 5'd4; eid = 16'hFFF0; eiu = 16'hFFF0;
        rst = 1; rst_wd = 1;
        m = mreset(); mw = mreset();
        #1;
        check_dut("main_rst", m, st_m, up_m, nrst_m, fat_m, cc_m, rc_m);
        check_dut("wd_rst", mw, st_w, up_w, nrst_w, fat_w, cc_w, rc_w);
        step();
        rst = 0; rst_wd = 0;

        // Bring-up latencies with width 4, upper lanes idle.
        n = 0;
        while (!nrst_m && n < 40) begin step(); n++; end
        chk("nrst_rise", n, RC);
        n = 0;
        while (st_m != 3'd2 && n < 40) begin step(); n++; end
        chk("enter_stable", n, 1);
        n = 0;
        while (!up_m && n < 40) begin step(); n++; end
        chk("up_latency", n, SC);

        // Glitch on lane 2 at stable count 8 restarts the window.
        hot = 1; step();
        chk("hot_nrst", 32'(nrst_m), 0);
        chk("hot_up", 32'(up_m), 0);
        n = 0;
        while (!nrst_m && n < 40) begin step(); n++; end
        chk("hot_nrst_rise", n, RC);
        n = 0;
        while (st_m != 3'd2 && n < 40) begin step(); n++; end
        for (int k = 0; k < 7; k++) step();
        eiu[2] = 1'b1; step(); eiu[2] = 1'b0;
        chk("glitch_wait", 32'(st_m), 1);
        n = 0;
        while (!up_m && n < 60) begin step(); n++; end
        chk("glitch_up_delay", n, SC + 1);

        // Lane 0 drops while up.
        for (int k = 0; k < 3; k++) begin
            eid[0] = 1'b1; step(); eid[0] = 1'b0;
`ifdef PCIE_LINK_SEQ_RETRAIN_EN
            wait_up("retrain_up");
            chk("retrain_cnt", 32'(rc_m), 32'(k + 1));
`else
            chk("drop_fatal", 32'(fat_m), 1);
            break;
`endif
        end
        areset_main();

        // Invalid widths behave as 16 lanes.
        for (int v = 0; v < 2; v++) begin
            lw = (v == 0) ? 5'd0 : 5'd20;
            eid = 16'h0; eiu = 16'h0;
            if (v == 0) eid[15] = 1'b1; else eiu[9] = 1'b1;
            areset_main();
            for (int k = 0; k < 40; k++) step();
            chk("wide_blocked", 32'(up_m), 0);
            eid = 16'h0; eiu = 16'h0;
            wait_up("wide_up");
        end

        // Random traffic.
        lw = 5'd4; clean_lanes();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) == 0) lw = 5'($urandom_range(0, 31));
            eid = 16'($urandom); eiu = 16'($urandom);
            w = (lw == 0 || lw > 16) ? 16 : int'(lw);
            for (int j = 0; j < w; j++) begin eid[j] = 0; eiu[j] = 0; end
            if ($urandom_range(0, 99) < 3) eid[$urandom_range(0, w - 1)] = 1'b1;
            hot    = ($urandom_range(0, 199) == 0);
            rst    = m.fatal || ($urandom_range(0, 499) == 0);
            rst_wd = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 0; rst_wd = 0;

        // Watchdog with lanes idle; expiry beats a coincident hot reset.
        lw = 5'd4; eid = 16'hFFFF; eiu = 16'h0;
        rst_wd = 1; step(); rst_wd = 0;
        n = 0;
        while (cc_w != 32'd49 && n < 100) begin step(); n++; end
        chk("wd_reach49", cc_w, 49);
        hot = 1; step();
        chk("wd_fatal", 32'(fat_w), 1);
        chk("wd_state", 32'(st_w), 7);
        chk("wd_frozen", cc_w, 50);
        for (int k = 0; k < 5; k++) step();
        hot = 1; step();
        chk("wd_hot_ignored", 32'(st_w), 7);
        rst_wd = 1;
        #1;
        check_dut("wd_async_rst", mreset(), st_w, up_w, nrst_w, fat_w, cc_w, rc_w);
        step();
        rst_wd = 0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
